// File: rtl/shift_sched.sv
// ============================================================================
// Module   : shift_sched
// Purpose  : Round-robin issue controller for the shared multi-cycle barrel
//            shifter; sequences start/done and returns tagged results.
// Option   : SHIFT_SCHED_ZERO_BYPASS_EN - zero-amount requests skip the shifter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sched #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 2,
    parameter int TAG_W = 5,
    localparam int SA_W = $clog2(XLEN),
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*XLEN-1:0]   req_data_i,
    input  logic [N_REQ*SA_W-1:0]   req_amount_i,
    input  logic [N_REQ-1:0]        req_left_i,
    input  logic [N_REQ-1:0]        req_arith_i,
    input  logic [N_REQ*TAG_W-1:0]  req_tag_i,

    input  logic                    flush_i,

    output logic                    sh_start_o,
    output logic [XLEN-1:0]         sh_data_o,
    output logic [SA_W-1:0]         sh_amount_o,
    output logic                    sh_left_o,
    output logic                    sh_arith_o,
    input  logic [XLEN-1:0]         sh_data_out_i,
    input  logic                    sh_done_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [XLEN-1:0]         rsp_data_o,
    output logic [TAG_W-1:0]        rsp_tag_o,
    output logic                    busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [ID_W:0] C_NREQ = (ID_W+1)'(N_REQ);

`ifdef SHIFT_SCHED_ZERO_BYPASS_EN
    localparam bit C_ZERO_BYPASS = 1'b1;
`else
    localparam bit C_ZERO_BYPASS = 1'b0;
`endif

    generate
        if (N_REQ < 2) begin : g_bad_nreq
            $error("shift_sched: N_REQ must be 2 or more");
        end
    endgenerate

    logic [2:0]       state_q,     state_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [XLEN-1:0]  op_data_q,   op_data_d;
    logic [SA_W-1:0]  op_amount_q, op_amount_d;
    logic             op_left_q,   op_left_d;
    logic             op_arith_q,  op_arith_d;
    logic [TAG_W-1:0] tag_q,       tag_d;
    logic [ID_W-1:0]  id_q,        id_d;
    logic [XLEN-1:0]  rsp_data_q,  rsp_data_d;
    logic             mask_q,      mask_d;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W:0]    idx_ext;
    logic [ID_W:0]    rr_nxt;
    logic             accept;
    logic [XLEN-1:0]  sel_data;
    logic [SA_W-1:0]  sel_amount;
    logic [TAG_W-1:0] sel_tag;

    // Rotating priority: scan ports starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_ext     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_ext = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_ext >= C_NREQ) begin
                idx_ext = idx_ext - C_NREQ;
            end
            if (!grant_found && req_valid_i[idx_ext[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_ext[ID_W-1:0];
            end
        end
    end

    assign accept     = (state_q == S_IDLE) && !flush_i && grant_found;
    assign sel_data   = req_data_i[int'(grant_idx)*XLEN +: XLEN];
    assign sel_amount = req_amount_i[int'(grant_idx)*SA_W +: SA_W];
    assign sel_tag    = req_tag_i[int'(grant_idx)*TAG_W +: TAG_W];

    always_comb begin
        rr_nxt = {1'b0, grant_idx} + (ID_W+1)'(1);
        if (rr_nxt >= C_NREQ) begin
            rr_nxt = '0;
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_data_q   <= '0;
            op_amount_q <= '0;
            op_left_q   <= 1'b0;
            op_arith_q  <= 1'b0;
            tag_q       <= '0;
            id_q        <= '0;
            rsp_data_q  <= '0;
            mask_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_data_q   <= op_data_d;
            op_amount_q <= op_amount_d;
            op_left_q   <= op_left_d;
            op_arith_q  <= op_arith_d;
            tag_q       <= tag_d;
            id_q        <= id_d;
            rsp_data_q  <= rsp_data_d;
            mask_q      <= mask_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_data_d   = op_data_q;
        op_amount_d = op_amount_q;
        op_left_d   = op_left_q;
        op_arith_d  = op_arith_q;
        tag_d       = tag_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        mask_d      = mask_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_data_d   = sel_data;
                    op_amount_d = sel_amount;
                    op_left_d   = req_left_i[grant_idx];
                    op_arith_d  = req_arith_i[grant_idx];
                    tag_d       = sel_tag;
                    id_d        = grant_idx;
                    rr_ptr_d    = rr_nxt[ID_W-1:0];
                    if (C_ZERO_BYPASS && (sel_amount == '0)) begin
                        rsp_data_d = sel_data;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    mask_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // First WAIT cycle still sees the previous op's done level.
                mask_d = 1'b0;
                if (flush_i) begin
                    state_d = S_DRAIN;
                end else if (sh_done_i && !mask_q) begin
                    rsp_data_d = sh_data_out_i;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                mask_d = 1'b0;
                if (sh_done_i && !mask_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
        sh_start_o  = (state_q == S_ISSUE) && !flush_i;
        rsp_valid_o = (state_q == S_RESP);
        busy_o      = (state_q != S_IDLE);
        sh_data_o   = op_data_q;
        sh_amount_o = op_amount_q;
        sh_left_o   = op_left_q;
        sh_arith_o  = op_arith_q;
        rsp_id_o    = id_q;
        rsp_data_o  = rsp_data_q;
        rsp_tag_o   = tag_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_sched.sv
// ============================================================================
// Module   : tb_shift_sched
// Purpose  : Directed, table-driven bench for shift_sched with a shifter model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sched;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int TW   = 5;
    localparam int SAW  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*XLEN-1:0] req_data;
    logic [NR*SAW-1:0] req_amount;
    logic [NR-1:0]     req_left;
    logic [NR-1:0]     req_arith;
    logic [NR*TW-1:0]  req_tag;
    logic              flush;
    logic              sh_start;
    logic [XLEN-1:0]   sh_data;
    logic [SAW-1:0]    sh_amount;
    logic              sh_left;
    logic              sh_arith;
    logic [XLEN-1:0]   sh_data_out;
    logic              sh_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [XLEN-1:0]   rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic              busy;

    shift_sched #(.XLEN(XLEN), .N_REQ(NR), .TAG_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .req_amount_i  (req_amount),
        .req_left_i    (req_left),
        .req_arith_i   (req_arith),
        .req_tag_i     (req_tag),
        .flush_i       (flush),
        .sh_start_o    (sh_start),
        .sh_data_o     (sh_data),
        .sh_amount_o   (sh_amount),
        .sh_left_o     (sh_left),
        .sh_arith_o    (sh_arith),
        .sh_data_out_i (sh_data_out),
        .sh_done_i     (sh_done),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .rsp_tag_o     (rsp_tag),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Shifter model: done level stays high through the cycle after start,
    // result appears sh_lat cycles after the start edge.
    int              sh_lat = 1;
    int              sh_cnt;
    logic [XLEN-1:0] model_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_done     <= 1'b0;
            sh_data_out <= '0;
            sh_cnt      <= 0;
            model_res   <= '0;
        end else if (sh_start) begin
            sh_cnt <= 1;
            if (sh_left)       model_res <= sh_data << sh_amount;
            else if (sh_arith) model_res <= $unsigned($signed(sh_data) >>> sh_amount);
            else               model_res <= sh_data >> sh_amount;
        end else if (sh_cnt != 0) begin
            if (sh_cnt == 1) sh_done <= 1'b0;
            if (sh_cnt >= sh_lat) begin
                sh_done     <= 1'b1;
                sh_data_out <= model_res;
                sh_cnt      <= 0;
            end else begin
                sh_cnt <= sh_cnt + 1;
            end
        end
    end

    int cyc, n_starts, n_hs;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sh_start) n_starts <= n_starts + 1;
        if (rst_n && rsp_valid && rsp_ready && !flush) n_hs <= n_hs + 1;
    end

    int n_tests, n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] d, input logic [4:0] a,
                           input logic l, input logic ar, input logic [4:0] t);
        req_data[p*XLEN +: XLEN] = d;
        req_amount[p*SAW +: SAW] = a;
        req_left[p]              = l;
        req_arith[p]             = ar;
        req_tag[p*TW +: TW]      = t;
    endtask

    // Raise valid on port p, wait for its grant, clock the handshake.
    task automatic issue(input int p, input logic [31:0] d, input logic [4:0] a,
                         input logic l, input logic ar, input logic [4:0] t);
        int ok;
        set_req(p, d, a, l, ar, t);
        req_valid[p] = 1'b1;
        #1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[p]) begin
                ok = 1;
                break;
            end
            step();
        end
        chk("accept", 64'(ok), 64'd1);
        step();
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(output int steps);
        steps = 0;
        while (!rsp_valid && steps < 60) begin
            step();
            steps++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [4:0]  amt;
        logic        left;
        logic        arith;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, s0, h0, bad, ng, nr, byp;
        int gp[4];
        int gc[4];
        logic [31:0] rd[2];
        int ri[2];
        logic [31:0] d0;
        logic [4:0]  t0;

        vt[0] = '{0, 32'h8000_0001, 5'd4,  1'b0, 1'b0, 5'd7,  32'h0800_0000};
        vt[1] = '{1, 32'hF000_0000, 5'd8,  1'b0, 1'b1, 5'd2,  32'hFFF0_0000};
        vt[2] = '{0, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 5'd11, 32'h8000_0000};
        vt[3] = '{1, 32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 5'd20, 32'hDEAD_BEEF};
        vt[4] = '{0, 32'h8765_4321, 5'd16, 1'b0, 1'b1, 5'd0,  32'hFFFF_8765};
        vt[5] = '{1, 32'h0000_00FF, 5'd4,  1'b1, 1'b0, 5'd31, 32'h0000_0FF0};

        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_amount = '0;
        req_left = '0; req_arith = '0; req_tag = '0; flush = 1'b0; rsp_ready = 1'b0;
        step();
        chk("reset_ctrl", {59'd0, req_ready, sh_start, rsp_valid, busy}, 64'd0);
        chk("reset_sh", {26'd0, sh_data, sh_amount, sh_left, sh_arith}, 64'd0);
        chk("reset_rsp", {26'd0, rsp_data, rsp_tag, rsp_id}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single-request vectors
        for (int v = 0; v < 6; v++) begin
            byp = 0;
`ifdef SHIFT_SCHED_ZERO_BYPASS_EN
            byp = (vt[v].amt == 5'd0) ? 1 : 0;
`endif
            s0 = n_starts;
            issue(vt[v].port, vt[v].data, vt[v].amt, vt[v].left, vt[v].arith, vt[v].tag);
            if (byp == 0) chk($sformatf("v%0d_start", v), 64'(sh_start), 64'd1);
            wait_rsp(st);
            chk($sformatf("v%0d_latency", v), 64'(st), (byp != 0) ? 64'd0 : 64'd3);
            chk($sformatf("v%0d_data", v), 64'(rsp_data), 64'(vt[v].exp));
            chk($sformatf("v%0d_tag", v), 64'(rsp_tag), 64'(vt[v].tag));
            chk($sformatf("v%0d_id", v), 64'(rsp_id), 64'(vt[v].port));
            chk($sformatf("v%0d_starts", v), 64'(n_starts - s0), (byp != 0) ? 64'd0 : 64'd1);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk($sformatf("v%0d_idle", v), 64'(busy), 64'd0);
        end

        // Contention: both ports valid, grants must alternate
        set_req(0, 32'h8000_0001, 5'd4, 1'b0, 1'b0, 5'd1);
        set_req(1, 32'hF000_0000, 5'd8, 1'b0, 1'b1, 5'd2);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        ng = 0; nr = 0;
        for (int i = 0; i < 80 && ng < 4; i++) begin
            if (req_ready != '0) begin
                gp[ng] = req_ready[1] ? 1 : 0;
                gc[ng] = cyc;
                ng++;
            end
            if (rsp_valid && nr < 2) begin
                rd[nr] = rsp_data;
                ri[nr] = int'(rsp_id);
                nr++;
            end
            step();
        end
        req_valid = '0;
        chk("cont_ngrants", 64'(ng), 64'd4);
        chk("cont_nrsp", 64'(nr), 64'd2);
        for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), 64'(gp[i]), 64'(i % 2));
        for (int i = 0; i < 3; i++) chk($sformatf("cont_gap%0d", i), 64'(gc[i+1] - gc[i]), 64'd5);
        chk("cont_rsp0", {31'd0, ri[0][0], rd[0]}, {32'd0, 32'h0800_0000});
        chk("cont_rsp1", {31'd0, ri[1][0], rd[1]}, {32'd1, 32'hFFF0_0000});
        for (int i = 0; i < 20 && busy; i++) step();
        rsp_ready = 1'b0;
        chk("cont_drained", 64'(busy), 64'd0);

        // Backpressure
        issue(0, 32'h0000_1234, 5'd4, 1'b1, 1'b0, 5'd3);
        wait_rsp(st);
        set_req(1, 32'h0000_0005, 5'd1, 1'b1, 1'b0, 5'd4);
        req_valid[1] = 1'b1;
        d0 = rsp_data; t0 = rsp_tag; bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!rsp_valid || rsp_data !== d0 || rsp_tag !== t0 || req_ready !== '0) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_data", 64'(d0), 64'h0001_2340);
        h0 = n_hs;
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        step(); step(); step();
        chk("bp_one_rsp", 64'(n_hs - h0), 64'd1);

        // Flush in WAIT -> drain without response
        sh_lat = 8;
        issue(0, 32'h0000_AAAA, 5'd1, 1'b1, 1'b0, 5'd5);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        h0 = n_hs;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_no_rsp", 64'(rsp_valid), 64'd0);
        set_req(1, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 5'd9);
        req_valid[1] = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (req_ready !== '0) bad++;
            step();
        end
        chk("drain_no_grant", 64'(bad), 64'd0);
        chk("drain_exit", 64'(busy), 64'd0);
        chk("drain_done_seen", 64'(sh_done), 64'd1);
        chk("drain_next_grant", 64'(req_ready), 64'd2);
        sh_lat = 1;
        step();
        req_valid = '0;
        wait_rsp(st);
        chk("post_drain_data", 64'(rsp_data), 64'h8000_0000);
        chk("post_drain_id", 64'(rsp_id), 64'd1);
        chk("drain_no_extra_rsp", 64'(n_hs - h0), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Flush in ISSUE
        issue(0, 32'h0000_0055, 5'd2, 1'b1, 1'b0, 5'd6);
        s0 = n_starts;
        flush = 1'b1;
        #1;
        chk("fi_no_start", 64'(sh_start), 64'd0);
        step();
        flush = 1'b0;
        chk("fi_busy", 64'(busy), 64'd0);
        chk("fi_starts", 64'(n_starts - s0), 64'd0);

        // Flush in RESP
        issue(1, 32'h0000_0003, 5'd1, 1'b0, 1'b0, 5'd8);
        wait_rsp(st);
        h0 = n_hs;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fr_busy", 64'(busy), 64'd0);
        chk("fr_dropped", 64'(rsp_valid), 64'd0);
        step();
        chk("fr_no_rsp", 64'(n_hs - h0), 64'd0);

        // Reset asserted in WAIT
        issue(0, 32'h0000_0001, 5'd3, 1'b1, 1'b0, 5'd13);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstw_ctrl", {59'd0, req_ready, sh_start, rsp_valid, busy}, 64'd0);
        chk("rstw_sh", {26'd0, sh_data, sh_amount, sh_left, sh_arith}, 64'd0);
        chk("rstw_rsp", {26'd0, rsp_data, rsp_tag, rsp_id}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        req_valid = 2'b11;
        #1;
        chk("rstw_rr_ptr", 64'(req_ready), 64'd1);
        req_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_sched.md
# shift_sched

Issue controller for the shared multi-cycle barrel shifter in the ALU. Accepts shift requests from up to N_REQ issue ports, grants one at a time by round-robin, sequences the shifter's start/done protocol, and returns the tagged result over a valid/ready response channel. A flush input kills the current operation and drains the shifter without producing a response.

## Interface
- XLEN, 32, datapath width; must equal core_config_pkg::XLEN.
- N_REQ, 2, number of requesters; must be 2 or more.
- TAG_W, 5, opaque tag width, e.g. destination register index.
- SA_W = $clog2(XLEN), derived, shift-amount width.
- ID_W = $clog2(N_REQ), derived, requester-index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-port request valid.
- req_ready  out  N_REQ  per-port request ready; one-hot or zero.
- req_data  in  N_REQ*XLEN  operand; port i is bits [i*XLEN +: XLEN].
- req_amount  in  N_REQ*SA_W  shift amount.
- req_left  in  N_REQ  1 = left shift.
- req_arith  in  N_REQ  1 = arithmetic right shift; ignored for left shifts.
- req_tag  in  N_REQ*TAG_W  tag, returned unchanged.
- flush  in  1  kills the operation in flight.
- sh_start  out  1  shifter start strobe.
- sh_data, sh_amount, sh_left, sh_arith  out  XLEN/SA_W/1/1  shifter operands.
- sh_data_out  in  XLEN  shifter result.
- sh_done  in  1  shifter done, as a level. It stays high until the cycle after the next start.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the granted requester.
- rsp_data  out  XLEN  shift result.
- rsp_tag  out  TAG_W  tag of the request.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Pick the first valid port at or after rr_ptr, wrapping modulo N_REQ.
  - Drive req_ready[g] = 1 combinationally for the granted port g only.
  - If flush is high, grant nothing.
  - On a handshake: latch the operands, tag and g into registers; set rr_ptr = g+1 modulo N_REQ; go to ISSUE.
- ISSUE:
  - sh_start = 1 for exactly one cycle; sh_* are driven from the registers.
  - Set mask = 1, then go to WAIT.
  - If flush is high: suppress sh_start and go to IDLE.
- WAIT:
  - In the first WAIT cycle mask is high, so a stale sh_done from the previous operation is ignored. mask clears after that cycle.
  - When sh_done is high and mask is low: rsp_data <= sh_data_out, then go to RESP.
  - If flush is high: go to DRAIN, regardless of sh_done.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_tag and rsp_id stay stable until rsp_ready.
  - If rsp_ready is high: go to IDLE.
  - If flush is high: drop the response and go to IDLE. flush has priority over rsp_ready.
- DRAIN:
  - req_ready = 0 and rsp_valid = 0.
  - Wait for sh_done high with mask low, then go to IDLE with no response.
  - flush is ignored in this state.
- sh_* operand outputs hold their registered values in every state. sh_start is high only in ISSUE.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: req_ready, sh_start, sh_data, sh_amount, sh_left, sh_arith, rsp_valid, rsp_id, rsp_data, rsp_tag, busy.
- Reset asserted mid-operation returns to IDLE immediately. The shifter shares rst_n, so no drain is needed.
- Request accepted at cycle T:
  - sh_start is high at T+1.
  - The earliest cycle sh_done is honoured is T+3.
  - rsp_valid rises the cycle after sh_done is honoured.
- Overhead beyond shifter latency: 3 cycles from accept to rsp_valid.
- Back-to-back: the next accept happens the cycle after the rsp handshake.
- Throughput is at most one operation in flight; the block is not pipelined.

## Configuration
- SHIFT_SCHED_ZERO_BYPASS_EN defined:
  - A granted request with amount 0 skips the shifter and goes IDLE -> RESP with rsp_data = req_data.
  - rsp_valid rises at T+1.
  - sh_start is never pulsed for that request.
- SHIFT_SCHED_ZERO_BYPASS_EN undefined: every request, including amount 0, goes through the shifter.

## Test plan
- Single request, port 0: data=0x8000_0001, amount=4, right logical, tag=7 -> sh_start pulses once; then rsp_valid with rsp_data=0x0800_0000, rsp_tag=7, rsp_id=0.
- Contention: ports 0 and 1 both valid continuously -> grants alternate 0,1,0,1. An arithmetic right shift of 0xF000_0000 by 8 returns 0xFFF0_0000.
- Backpressure: rsp_ready held low for 10 cycles -> rsp_* stay stable, req_ready = 0, and there is exactly one response once rsp_ready rises.
- Flush in WAIT -> state goes to DRAIN; there is no response; the next request is not accepted before sh_done; the following shift of 0x1 by 31 left returns 0x8000_0000.
- Flush in ISSUE and flush in RESP -> no sh_start and a dropped response respectively; busy drops the next cycle.
- With SHIFT_SCHED_ZERO_BYPASS_EN: amount 0, data=0xDEAD_BEEF -> rsp_valid at T+1 with 0xDEAD_BEEF and no sh_start. Separately, rst_n pulsed in WAIT -> all outputs are 0 and rr_ptr = 0.
